// File: rtl/max_accumulator_if.sv
// Handshake/result bundle for max_accumulator: sample stream in, frame maximum and status out.
interface max_accumulator_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned COUNT = 8
);
    localparam int unsigned CW = $clog2(COUNT + 1);

    logic             start;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] max;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;

    modport master (
        output start, d, d_valid,
        input  d_ready, max, count, busy, done
    );

    modport slave (
        input  start, d, d_valid,
        output d_ready, max, count, busy, done
    );
endinterface

// File: rtl/max_accumulator.sv
// Frame-based running maximum: folds COUNT accepted samples through max_selector2
// and presents the frame maximum with a done flag.
module max_selector2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y
);
    // Strict compare keeps d0 on ties.
    assign y = (d1 > d0) ? d1 : d0;
endmodule

module max_accumulator #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned COUNT = 8
) (
    input  logic               clk,
    input  logic               reset,
    max_accumulator_if.slave   bus
);
    localparam int unsigned   CW   = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] max_q, max_n;
    logic [CW-1:0]    count_q, count_n;
    logic [WIDTH-1:0] sel_y;
    logic             ready;
    logic             xfer;

    max_selector2 #(.WIDTH(WIDTH)) u_sel (
        .d0 (max_q),
        .d1 (bus.d),
        .y  (sel_y)
    );

    assign ready = (state == ACCUM);
    assign xfer  = bus.d_valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            max_q   <= '0;
            count_q <= '0;
        end else begin
            state   <= state_n;
            max_q   <= max_n;
            count_q <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        max_n   = max_q;
        count_n = count_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = ACCUM;
                    max_n   = '0;
                    count_n = '0;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    max_n   = sel_y;
                    count_n = count_q + CW'(1);
                    if (count_q == LAST) state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.d_ready = ready;
    assign bus.busy    = ready;
    assign bus.done    = (state == DONE);
    assign bus.max     = max_q;
    assign bus.count   = count_q;
endmodule

// File: tb/tb_max_accumulator.sv
// Directed bench for max_accumulator (WIDTH=4, COUNT=8) plus a COUNT=1 instance.
module tb_max_accumulator;
    logic clk;
    logic reset;
    logic reset1;

    max_accumulator_if #(.WIDTH(4), .COUNT(8)) bus  ();
    max_accumulator_if #(.WIDTH(4), .COUNT(1)) bus1 ();

    max_accumulator #(.WIDTH(4), .COUNT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    max_accumulator #(.WIDTH(4), .COUNT(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] mx;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: 0=IDLE 1=ACCUM 2=DONE
    int         m_state = 0;
    logic [3:0] m_max   = '0;
    logic [3:0] m_cnt   = '0;

    logic [3:0] seq1 [8] = '{4'd3, 4'd9, 4'd2, 4'd15, 4'd0, 4'd7, 4'd15, 4'd1};
    logic [3:0] step1[8] = '{4'd3, 4'd9, 4'd9, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one cycle from a negedge, predicts the result, checks it at the next negedge.
    task automatic cycle(input logic r, input logic s, input logic [3:0] dd, input logic v);
        exp_t e;
        reset       = r;
        bus.start   = s;
        bus.d       = dd;
        bus.d_valid = v;
        if (r) begin
            m_state = 0; m_max = '0; m_cnt = '0;
        end else if (m_state == 1) begin
            if (v) begin
                if (dd > m_max) m_max = dd;
                m_cnt = m_cnt + 4'd1;
                if (m_cnt == 4'd8) m_state = 2;
            end
        end else if (s) begin
            m_state = 1; m_max = '0; m_cnt = '0;
        end
        e.mx   = m_max;
        e.cnt  = m_cnt;
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("max",     {28'd0, bus.max},     {28'd0, e.mx});
        check("count",   {28'd0, bus.count},   {28'd0, e.cnt});
        check("busy",    {31'd0, bus.busy},    {31'd0, e.busy});
        check("d_ready", {31'd0, bus.d_ready}, {31'd0, e.busy});
        check("done",    {31'd0, bus.done},    {31'd0, e.done});
    endtask

    initial begin
        reset        = 1'b1;
        reset1       = 1'b1;
        bus.start    = 1'b0;
        bus.d        = '0;
        bus.d_valid  = 1'b0;
        bus1.start   = 1'b0;
        bus1.d       = '0;
        bus1.d_valid = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 1'b1, 4'd5, 1'b1);
        check("rst_max",   {28'd0, bus.max},   32'd0);
        check("rst_ready", {31'd0, bus.d_ready}, 32'd0);

        // 1: back-to-back frame
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        check("t1_max_cleared", {28'd0, bus.max}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, seq1[i], 1'b1);
            check("t1_step", {28'd0, bus.max}, {28'd0, step1[i]});
        end
        check("t1_done",  {31'd0, bus.done}, 32'd1);
        check("t1_count", {28'd0, bus.count}, 32'd8);
        cycle(1'b0, 1'b0, 4'd14, 1'b1);
        check("t1_hold", {28'd0, bus.max}, 32'd15);

        // 2: alternate valid gaps
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 4'd13, 1'b0);
            cycle(1'b0, 1'b0, seq1[i], 1'b1);
        end
        check("t2_max",  {28'd0, bus.max},  32'd15);
        check("t2_done", {31'd0, bus.done}, 32'd1);

        // 3: all zeros, then all fifteens
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'd0, 1'b1);
        check("t3_zero_max",  {28'd0, bus.max},  32'd0);
        check("t3_zero_done", {31'd0, bus.done}, 32'd1);
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'd15, 1'b1);
        check("t3_full_max", {28'd0, bus.max}, 32'd15);

        // 4: restart from DONE clears max
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        check("t4_cleared", {28'd0, bus.max}, 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'd4, 1'b1);
        check("t4_max",  {28'd0, bus.max},  32'd4);
        check("t4_done", {31'd0, bus.done}, 32'd1);

        // 5: reset mid-frame, then samples in IDLE are ignored
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, seq1[i], 1'b1);
        check("t5_pre_max", {28'd0, bus.max}, 32'd9);
        cycle(1'b1, 1'b0, 4'd12, 1'b1);
        check("t5_max",   {28'd0, bus.max},   32'd0);
        check("t5_count", {28'd0, bus.count}, 32'd0);
        check("t5_busy",  {31'd0, bus.busy},  32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'd12, 1'b1);
        check("t5_idle_count", {28'd0, bus.count}, 32'd0);

        // 6: start held through ACCUM
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, (i == 0) ? 4'd0 : seq1[i-1], (i != 0));
        check("t6_count", {28'd0, bus.count}, 32'd8);
        check("t6_done",  {31'd0, bus.done},  32'd1);
        cycle(1'b0, 1'b0, 4'd0, 1'b0);

        // COUNT=1 instance
        reset1 = 1'b1;
        @(negedge clk);
        reset1     = 1'b0;
        bus1.start = 1'b1;
        @(negedge clk);
        check("c1_busy", {31'd0, bus1.busy}, 32'd1);
        bus1.start   = 1'b0;
        bus1.d       = 4'd6;
        bus1.d_valid = 1'b1;
        @(negedge clk);
        bus1.d_valid = 1'b0;
        check("c1_max",   {28'd0, bus1.max},   32'd6);
        check("c1_done",  {31'd0, bus1.done},  32'd1);
        check("c1_count", {31'd0, bus1.count}, 32'd1);
        check("c1_ready", {31'd0, bus1.d_ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
